mem_cache_ctrl: RTL

Direct-mapped, write-back, write-allocate data cache controller that responds to the processor's memory-stage (or fetch) port and initiates line transfers to the backing memory. Hits finish combinationally in the request cycle. Misses hold `Stall` high while a dirty victim is written back and the new line is filled, then complete with a one-cycle `Done`. It is the responder to the pipeline's `stall_mem` / `err_mem` handshake.

---
 rtl/mem_cache_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_cache_ctrl.sv
// mem_cache_ctrl
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits complete combinationally in the request cycle. A miss holds Stall
// while a dirty victim line is written back (WB0-WB3) and the requested
// line is filled (FILL0-FILL3), then completes with a one-cycle Done.
//
// Parameters:
//   LINES      number of cache lines (power of 2)
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   Addr, DataIn          byte address / write data from the requester
//   Rd, Wr                read / write request (held stable while Stall)
//   DataOut               read data, nonzero only with Done on a read
//   Done, Stall           access complete / access in progress
//   CacheHit              with Done: 1 = hit, 0 = completed after a miss
//   err                   illegal request (Rd&Wr, or odd address)
//   mem_req, mem_wr       backing-memory word request (held until ack), 1=write
//   mem_addr, mem_wdata   word-aligned backing address / write-back data
//   mem_ack, mem_rdata    transfer accepted / fill data
// Optional feature macro: CACHE_STATS_EN adds saturating hit_cnt/miss_cnt
// outputs, cleared by rst.
module mem_cache_ctrl #(
  parameter int LINES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int IW = $clog2(LINES);
  localparam int TW = 16 - 3 - IW;

  typedef enum logic [3:0] {
    IDLE, WB0, WB1, WB2, WB3, FILL0, FILL1, FILL2, FILL3, DONE
  } state_e;

  state_e state_q, state_d, seq_next;

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [15:0]      data_q [LINES][4];

  logic [IW-1:0] idx;
  logic [TW-1:0] req_tag;
  logic [1:0]    word;
  logic [1:0]    beat;
  logic          hit;
  logic          illegal;
  logic          word_we;
  logic          fill_we;
  logic          fill_last;
  logic          miss_start;

  assign idx     = Addr[3+IW-1:3];
  assign req_tag = Addr[15:3+IW];
  assign word    = Addr[2:1];
  assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);
  assign illegal = (Rd && Wr) || (Addr[0] && (Rd || Wr));

  // Beat number and successor state for the transfer states.
  always_comb begin
    beat     = 2'd0;
    seq_next = IDLE;
    unique case (state_q)
      WB0:     begin beat = 2'd0; seq_next = WB1;   end
      WB1:     begin beat = 2'd1; seq_next = WB2;   end
      WB2:     begin beat = 2'd2; seq_next = WB3;   end
      WB3:     begin beat = 2'd3; seq_next = FILL0; end
      FILL0:   begin beat = 2'd0; seq_next = FILL1; end
      FILL1:   begin beat = 2'd1; seq_next = FILL2; end
      FILL2:   begin beat = 2'd2; seq_next = FILL3; end
      FILL3:   begin beat = 2'd3; seq_next = DONE;  end
      default: begin beat = 2'd0; seq_next = IDLE;  end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    DataOut    = '0;
    Done       = 1'b0;
    Stall      = 1'b0;
    CacheHit   = 1'b0;
    err        = 1'b0;
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    word_we    = 1'b0;
    fill_we    = 1'b0;
    fill_last  = 1'b0;
    miss_start = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Rd || Wr) begin
          if (illegal) begin
            err = 1'b1;
          end else if (hit) begin
            Done     = 1'b1;
            CacheHit = 1'b1;
            if (Rd) DataOut = data_q[idx][word];
            else    word_we = 1'b1;
          end else begin
            Stall      = 1'b1;
            miss_start = 1'b1;
            state_d    = (valid_q[idx] && dirty_q[idx]) ? WB0 : FILL0;
          end
        end
      end
      WB0, WB1, WB2, WB3: begin
        Stall     = 1'b1;
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {tag_q[idx], idx, beat, 1'b0};
        mem_wdata = data_q[idx][beat];
        if (mem_ack) state_d = seq_next;
      end
      FILL0, FILL1, FILL2, FILL3: begin
        Stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {req_tag, idx, beat, 1'b0};
        if (mem_ack) begin
          fill_we   = 1'b1;
          fill_last = (state_q == FILL3);
          state_d   = seq_next;
        end
      end
      DONE: begin
        Done = 1'b1;
        if (Rd)      DataOut = data_q[idx][word];
        else if (Wr) word_we = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset takes effect in its own cycle: outputs and array writes are
    // suppressed so a partially filled line can never be committed.
    if (rst) begin
      DataOut    = '0;
      Done       = 1'b0;
      Stall      = 1'b0;
      CacheHit   = 1'b0;
      err        = 1'b0;
      mem_req    = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      word_we    = 1'b0;
      fill_we    = 1'b0;
      fill_last  = 1'b0;
      miss_start = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill_last) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
        tag_q[idx]   <= req_tag;
      end
      if (word_we) dirty_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we)      data_q[idx][beat] <= mem_rdata;
    else if (word_we) data_q[idx][word] <= DataIn;
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (Done && CacheHit && (hit_cnt != '1)) hit_cnt <= hit_cnt + 16'd1;
      if (miss_start && (miss_cnt != '1))      miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule
